// File: rtl/shift_store_unloader.sv
// Parallel-in, serial-out unloader: captures Length words in one load and emits
// them oldest-first (store[Length-1]) on a valid/ready stream.
module shift_store_unloader #(
  parameter  int N      = 8,
  parameter  int Length = 3,
  localparam int CW     = $clog2(Length + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       load_valid_i,
  output logic                       load_ready_o,
  input  logic [Length-1:0][N-1:0]   load_data_i,
  input  logic [N-1:0]               fill_val_i,
  input  logic                       abort_i,
  output logic [N-1:0]               data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic [CW-1:0]              count_o
);

  // Handshake rules for both ports: a transfer completes on a cycle where the
  // producer's valid and the consumer's ready are both high at the rising edge.
  // load_ready_o may depend combinationally on ready_i; abort_i suppresses the
  // load transfer even when valid and ready are both high.

  logic [Length-1:0][N-1:0] store_q;
  logic [CW-1:0]            count_q;
  logic                     load_acc;
  logic                     beat_acc;

  assign data_o       = store_q[Length-1];
  assign count_o      = count_q;
  assign valid_o      = (count_q != '0);
  assign last_o       = (count_q == CW'(1));
  assign load_ready_o = !valid_o || (last_o && ready_i);
  assign load_acc     = load_valid_i && load_ready_o && !abort_i;
  assign beat_acc     = valid_o && ready_i;

  // The state is IDLE when count_q is zero and SHIFT otherwise; count_o exposes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      store_q <= '0;
      count_q <= '0;
    end else if (abort_i) begin
      count_q <= '0;
    end else if (load_acc) begin
      store_q <= load_data_i;
      count_q <= CW'(Length);
    end else if (beat_acc) begin
      for (int i = Length - 1; i > 0; i--) begin
        store_q[i] <= store_q[i-1];
      end
      store_q[0] <= fill_val_i;
      count_q    <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_shift_store_unloader.sv
// Directed bench for shift_store_unloader: a queue-based model checked every
// cycle, plus literal expectations, a loopback store and a Length=1 instance.
module tb_shift_store_unloader;
  localparam int N   = 8;
  localparam int LEN = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   load_valid = 1'b0;
  logic [LEN-1:0][N-1:0]  ld = '0;
  logic [N-1:0]           fill = '0;
  logic                   abort = 1'b0;
  logic                   ready = 1'b0;
  logic                   load_ready;
  logic [N-1:0]           data;
  logic                   valid;
  logic                   last;
  logic [1:0]             count;

  shift_store_unloader #(.N(N), .Length(LEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_data_i(ld), .fill_val_i(fill), .abort_i(abort), .data_o(data),
    .valid_o(valid), .ready_i(ready), .last_o(last), .count_o(count)
  );

  // Length=1 instance for the single-word boundary
  logic [0:0][N-1:0] ld1 = '0;
  logic              load_ready1;
  logic [N-1:0]      data1;
  logic              valid1;
  logic              last1;
  logic [0:0]        count1;

  shift_store_unloader #(.N(N), .Length(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .load_valid_i(load_valid), .load_ready_o(load_ready1),
    .load_data_i(ld1), .fill_val_i(fill), .abort_i(abort), .data_o(data1),
    .valid_o(valid1), .ready_i(ready), .last_o(last1), .count_o(count1)
  );

  // ---------------- downstream shift_reg_with_store ----------------
  logic [N-1:0] lb [LEN];
  always @(posedge clk) begin
    if (valid && ready) begin
      lb[2] <= lb[1];
      lb[1] <= lb[0];
      lb[0] <= data;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] got_q [$];   // words the consumer accepted
  logic [N-1:0] exp_q [$];   // words the consumer must accept

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_stream(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- model: remaining words as a queue, front is emitted next ----------------
  logic [N-1:0] m_q [$];
  int           m_cnt;
  initial begin
    for (int i = 0; i < LEN; i++) m_q.push_back('0);
    m_cnt = 0;
  end

  always @(negedge clk) begin
    logic exp_lr;
    logic take_load;
    logic take_beat;
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < LEN; i++) m_q.push_back('0);
      m_cnt = 0;
    end
    exp_lr = (m_cnt == 0) || (m_cnt == 1 && ready);
    check("data_o", data, m_q[0]);
    check("valid_o", valid, m_cnt != 0);
    check("last_o", last, m_cnt == 1);
    check("count_o", count, m_cnt);
    check("load_ready_o", load_ready, exp_lr);
    if (rst_n) begin
      take_beat = (m_cnt != 0) && ready;
      take_load = load_valid && exp_lr && !abort;
      if (take_beat) got_q.push_back(m_q[0]);
      if (abort) begin
        m_cnt = 0;
      end else if (take_load) begin
        m_q.delete();
        for (int i = LEN - 1; i >= 0; i--) m_q.push_back(ld[i]);
        m_cnt = LEN;
      end else if (take_beat) begin
        void'(m_q.pop_front());
        m_q.push_back(fill);
        m_cnt = m_cnt - 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [N-1:0] w2, input logic [N-1:0] w1, input logic [N-1:0] w0);
    load_valid = 1'b1;
    ld[2] = w2;
    ld[1] = w1;
    ld[0] = w0;
  endtask

  task automatic lit(input string name, input logic [N-1:0] d, input int c, input logic v, input logic l);
    check({name, "_data"}, data, d);
    check({name, "_count"}, count, c);
    check({name, "_valid"}, valid, v);
    check({name, "_last"}, last, l);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    step();
    step();
    lit("reset", 8'h00, 0, 1'b0, 1'b0);
    check("reset_lr", load_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // basic serialization
    ready = 1'b1;
    fill = 8'h00;
    offer(8'hA1, 8'hB2, 8'hC3);
    step();
    load_valid = 1'b0;
    lit("basic0", 8'hA1, 3, 1'b1, 1'b0);
    step();
    lit("basic1", 8'hB2, 2, 1'b1, 1'b0);
    step();
    lit("basic2", 8'hC3, 1, 1'b1, 1'b1);
    step();
    lit("basic_idle", 8'h00, 0, 1'b0, 1'b0);
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    check_stream("basic");

    // backpressure
    ready = 1'b0;
    offer(8'hA1, 8'hB2, 8'hC3);
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lit($sformatf("bp_hold%0d", i), 8'hA1, 3, 1'b1, 1'b0);
      if (i == 4) ready = 1'b1;
      step();
    end
    lit("bp1", 8'hB2, 2, 1'b1, 1'b0);
    step();
    lit("bp2", 8'hC3, 1, 1'b1, 1'b1);
    step();
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    check_stream("bp");

    // back-to-back loads; second load is held from mid-stream
    offer(8'hA1, 8'hB2, 8'hC3);
    step();
    step();
    offer(8'h11, 8'h22, 8'h33);
    #1;
    check("b2b_mid_lr", load_ready, 1'b0);
    step();
    #1;
    check("b2b_last_lr", load_ready, 1'b1);
    step();
    load_valid = 1'b0;
    lit("b2b_second", 8'h11, 3, 1'b1, 1'b0);
    step();
    step();
    lit("b2b_tail", 8'h33, 1, 1'b1, 1'b1);
    step();
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'h11, 8'h22, 8'h33};
    check_stream("b2b");

    // abort after the first word, with loads offered around it
    offer(8'hA1, 8'hB2, 8'hC3);
    step();
    load_valid = 1'b0;
    step();
    ready = 1'b0;
    abort = 1'b1;
    offer(8'h11, 8'h22, 8'h33);
    step();
    lit("abort_next", 8'hB2, 0, 1'b0, 1'b0);
    #1;
    check("abort_idle_lr", load_ready, 1'b1);
    step();
    lit("abort_noload", 8'hB2, 0, 1'b0, 1'b0);
    abort = 1'b0;
    step();
    load_valid = 1'b0;
    lit("abort_reload", 8'h11, 3, 1'b1, 1'b0);
    ready = 1'b1;
    step();
    step();
    step();
    exp_q = '{8'hA1, 8'h11, 8'h22, 8'h33};
    check_stream("abort");

    // asynchronous reset mid-stream
    offer(8'hA1, 8'hB2, 8'hC3);
    step();
    load_valid = 1'b0;
    step();
    lit("pre_rst", 8'hB2, 2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_rst", 8'h00, 0, 1'b0, 1'b0);
    check("async_rst_lr", load_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    lit("post_rst", 8'h00, 0, 1'b0, 1'b0);
    exp_q = '{8'hA1};
    check_stream("rst");

    // loopback into a downstream store, with a non-zero fill
    fill = 8'h5A;
    offer(8'hA1, 8'hB2, 8'hC3);
    step();
    load_valid = 1'b0;
    step();
    step();
    step();
    check("lb2", lb[2], 8'hA1);
    check("lb1", lb[1], 8'hB2);
    check("lb0", lb[0], 8'hC3);
    lit("fill_idle", 8'h5A, 0, 1'b0, 1'b0);
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    check_stream("lb");

    // Length=1: every word is last, back-to-back loads of one word
    ld1[0] = 8'h77;
    load_valid = 1'b1;
    offer(8'h01, 8'h02, 8'h03);
    step();
    check("l1_data0", data1, 8'h77);
    check("l1_last0", last1, 1'b1);
    check("l1_count0", count1, 1'b1);
    check("l1_lr", load_ready1, 1'b1);
    ld1[0] = 8'h88;
    load_valid = 1'b0;
    step();
    check("l1_done", valid1, 1'b0);
    step();
    step();
    exp_q = '{8'h01, 8'h02, 8'h03};
    check_stream("l1_main");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_store_unloader.md
# shift_store_unloader

Parallel-in, serial-out companion to `shift_reg_with_store`. It captures a full `Length`-word store in one parallel load, then emits the words one per beat on a valid/ready stream. The oldest word (`store[Length-1]`) is emitted first. Feeding the stream into `shift_reg_with_store` with `en_i` equal to the accepted beat rebuilds the identical store array there. It sits between a layer buffer that produces a whole word vector and a downstream serial consumer.

## Interface
- `N`, default 8: width of one data word.
- `Length`, default 3: number of words per load. Must be ≥ 1.
- `clk_i` input, 1 bit: clock. All state updates on its rising edge.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `load_valid_i` input, 1 bit: `load_data_i` holds a store to capture.
- `load_ready_o` output, 1 bit: the block can accept a load this cycle.
- `load_data_i` input, N × [Length-1:0]: parallel store to serialize. Index Length-1 is emitted first.
- `fill_val_i` input, N bits: value shifted into `store[0]` on each accepted beat.
- `abort_i` input, 1 bit: synchronous discard of remaining words.
- `data_o` output, N bits: current word, always equal to `store[Length-1]`.
- `valid_o` output, 1 bit: `data_o` is a live word.
- `ready_i` input, 1 bit: the consumer accepts `data_o` this cycle.
- `last_o` output, 1 bit: the current word is the final word of the load.
- `count_o` output, $clog2(Length+1) bits: words remaining, including the current one.

## Operation
- Internal state: register array `store[Length-1:0]` of N bits each, plus the down-counter `count_o`. Two states derive from the counter: IDLE when `count_o`==0, SHIFT otherwise.
- `valid_o` = (`count_o` != 0), registered via the counter.
- `last_o` = `valid_o` && (`count_o`==1).
- `load_ready_o` = IDLE || (`last_o` && `ready_i`). This is combinational from `ready_i` and allows back-to-back loads with no bubble.
- Load accepted (`load_valid_i` && `load_ready_o` && !`abort_i`):
  - `store[i]` <= `load_data_i[i]` for all i.
  - `count_o` <= Length.
- Beat accepted (`valid_o` && `ready_i`) with no load in the same cycle:
  - `store[i]` <= `store[i-1]` for i ≥ 1.
  - `store[0]` <= `fill_val_i`.
  - `count_o` decrements.
  - IDLE is entered after the last beat.
- Load and last beat in the same cycle: the load wins for `store` and `count_o`. The last word is still accepted by the consumer.
- `valid_o` && !`ready_i`: `store`, `data_o` and `count_o` hold unchanged. No word is lost or duplicated.
- `abort_i`=1 has the highest priority:
  - `count_o` <= 0 and `store` is unchanged.
  - A load presented in the same cycle is not accepted.
  - `load_ready_o` still reflects the pre-abort state, but no handshake completes.
- `load_valid_i` in SHIFT (other than on the last beat) is ignored. The source must hold it.
- Reset (`rst_ni`=0, any time, including mid-stream):
  - All `store` = 0 and `count_o` = 0, so `data_o` = 0, `valid_o` = 0, `last_o` = 0.
  - `load_ready_o` = 1.
  - Any partially emitted load is lost.

## Timing
- Load to first word: 1 cycle. Words loaded at edge k are visible on `data_o`/`valid_o` after edge k.
- Throughput: 1 word per cycle with `ready_i` held high. Length words take Length cycles.
- Back-to-back loads give a continuous stream with no idle cycle.
- `data_o`, `valid_o`, `last_o` and `count_o` are registered-only outputs. `load_ready_o` is the only combinational output.
- Length=1: `last_o` is asserted on every word, and each load completes in one beat.
- Counter arithmetic is unsigned and never wraps: it decrements only when non-zero.

## Test plan
- **Basic serialization.** N=8, Length=3; load [2]=0xA1, [1]=0xB2, [0]=0xC3 with `ready_i`=1 and `fill_val_i`=0x00.
  - `data_o` = 0xA1, 0xB2, 0xC3 on three consecutive cycles.
  - `count_o` = 3, 2, 1.
  - `last_o` is high only with 0xC3.
  - `valid_o` = 0 afterwards and `data_o` = 0x00.
- **Backpressure.** Same load; `ready_i`=0 for 4 cycles after the first word, then 1.
  - 0xA1 holds for 5 cycles with `count_o`=3.
  - The sequence then completes with no duplicate or missing word.
- **Back-to-back loads.** Second load 0x11/0x22/0x33 presented during the last beat of the first load.
  - `load_ready_o`=1 in that cycle.
  - Stream is 0xA1, 0xB2, 0xC3, 0x11, 0x22, 0x33 with no gap.
- **Abort.** `abort_i` pulsed after 0xA1 is accepted.
  - Next cycle `valid_o`=0 and `count_o`=0.
  - A load offered during the abort cycle is not taken; the same load offered one cycle later is taken.
- **Reset mid-stream.** `rst_ni` dropped asynchronously while `count_o`=2.
  - All outputs clear immediately: `valid_o`=0, `data_o`=0, `count_o`=0.
  - `load_ready_o`=1.
- **Loopback.** Stream drives `shift_reg_with_store` (N=8, Length=3) with `en_i` = `valid_o` && `ready_i`.
  - After 3 beats, its `store_o` equals the loaded vector: [2]=0xA1, [1]=0xB2, [0]=0xC3.
